obc_dft_sequencer: RTL and testbench

Bit-serial controller for the 16-point OBC distributed-arithmetic DFT. It accepts a frame of 16 signed samples and, for each of the 16 DFT bins in turn, drives one bit-slice per cycle into the coefficient ROM bank, MSB first. It sums the eight ROM partial words and Horner-accumulates them, applying the sign-slice negation and the OBC offset term. It sits between the sample buffer and the output formatter, and it is the only block that drives ROM select inputs.

---
 rtl/obc_pkg.sv | 19 +
 rtl/obc_dft_sequencer_if.sv | 34 +++
 rtl/obc_slice_adder.sv | 20 ++
 rtl/obc_dft_sequencer.sv | 143 ++++++++++++++
 tb/tb_obc_dft_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/obc_pkg.sv
// Shared constants and types for the bit-serial OBC distributed-arithmetic DFT.
package obc_pkg;

    localparam int N_PTS   = 16;
    localparam int N_PAIRS = 8;
    localparam int ROM_W   = 32;
    localparam int BIN_W   = 4;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = ROM_W + 3 + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    typedef logic signed [ROM_W-1:0] rom_word_t;

endpackage

// File: rtl/obc_dft_sequencer_if.sv
// Frame input, coefficient ROM bank and result handshake of the DFT sequencer.
interface obc_dft_sequencer_if
    import obc_pkg::*;
#(
    parameter int DATA_W = obc_pkg::DATA_W,
    parameter int ROM_W  = obc_pkg::ROM_W,
    parameter int ACC_W  = ROM_W + 3 + DATA_W
);

    logic                       in_valid;
    logic                       in_ready;
    logic [N_PTS*DATA_W-1:0]    in_data;
    logic [BIN_W-1:0]           rom_bin;
    logic [N_PTS-1:0]           rom_bits;
    logic [N_PAIRS*ROM_W-1:0]   rom_word;
    logic [ROM_W-1:0]           rom_off;
    logic                       y_valid;
    logic                       y_ready;
    logic [ACC_W-1:0]           y_data;
    logic [BIN_W-1:0]           y_bin;
    logic                       y_last;

    // master is the sequencer itself; slave is the sample buffer, ROM bank and formatter side
    modport master (
        input  in_valid, in_data, rom_word, rom_off, y_ready,
        output in_ready, rom_bin, rom_bits, y_valid, y_data, y_bin, y_last
    );

    modport slave (
        output in_valid, in_data, rom_word, rom_off, y_ready,
        input  in_ready, rom_bin, rom_bits, y_valid, y_data, y_bin, y_last
    );

endinterface

// File: rtl/obc_slice_adder.sv
// Sums the eight signed ROM partial words of one bit-slice with three guard bits.
module obc_slice_adder
    import obc_pkg::*;
#(
    parameter int ROM_W = obc_pkg::ROM_W,
    parameter int SUM_W = ROM_W + 3
) (
    input  logic [N_PAIRS*ROM_W-1:0] words,
    output logic signed [SUM_W-1:0]  sum
);

    // NOTE: combinational accumulation uses blocking '=' so each iteration sees the previous partial sum.
    always_comb begin
        sum = '0;
        for (int p = 0; p < N_PAIRS; p++) begin
            sum = sum + SUM_W'($signed(words[p*ROM_W +: ROM_W]));
        end
    end

endmodule

// File: rtl/obc_dft_sequencer.sv
// Bit-serial OBC DFT controller: walks 16 bins x 16 slices MSB first, Horner-accumulating ROM sums.
module obc_dft_sequencer
    import obc_pkg::*;
#(
    parameter int DATA_W = obc_pkg::DATA_W,
    parameter int ROM_W  = obc_pkg::ROM_W,
    parameter int N_BIN  = 16,
    parameter int ACC_W  = ROM_W + 3 + DATA_W
) (
    input logic                clk,
    input logic                rst,
    obc_dft_sequencer_if.master bus
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int SUM_W = ROM_W + 3;
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(N_BIN - 1);

    state_t                   state;
    logic [BIN_W-1:0]         bin;
    logic [BIT_W-1:0]         bit_idx;
    logic [DATA_W-1:0]        samples [N_PTS];
    logic signed [ACC_W-1:0]  acc;
    logic                     in_ready_q;
    logic                     y_valid_q;
    logic signed [ACC_W-1:0]  y_data_q;
    logic [BIN_W-1:0]         y_bin_q;
    logic                     y_last_q;

    logic signed [SUM_W-1:0]  slice_sum;
    logic signed [ACC_W-1:0]  s_ext;
    logic signed [ACC_W-1:0]  off_ext;
    logic signed [ACC_W-1:0]  horner;
    logic [N_PTS-1:0]         rom_bits_c;
    logic [BIN_W-1:0]         rom_bin_c;
    logic                     accept;

    obc_slice_adder #(
        .ROM_W (ROM_W),
        .SUM_W (SUM_W)
    ) u_slice_adder (
        .words (bus.rom_word),
        .sum   (slice_sum)
    );

    assign accept  = in_ready_q && bus.in_valid;
    assign s_ext   = ACC_W'(slice_sum);
    assign off_ext = ACC_W'($signed(bus.rom_off));
    assign horner  = (acc <<< 1) + s_ext;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rom_bits_c = '0;
        rom_bin_c  = '0;
        if (state == RUN) begin
            rom_bin_c = bin;
            for (int n = 0; n < N_PTS; n++) begin
                rom_bits_c[n] = samples[n][bit_idx];
            end
        end
    end

    // NOTE: the sample register is plain data with no reset; it is only read after an accept loads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int n = 0; n < N_PTS; n++) begin
                samples[n] <= bus.in_data[n*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: all state updates use non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bin        <= '0;
            bit_idx    <= '0;
            acc        <= '0;
            in_ready_q <= 1'b1;
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            y_bin_q    <= '0;
            y_last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin        <= '0;
                        bit_idx    <= BIT_TOP;
                        acc        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // The MSB slice carries negative weight in two's complement.
                    if (bit_idx == BIT_TOP) begin
                        acc <= -s_ext;
                    end else begin
                        acc <= horner;
                    end
                    if (bit_idx == '0) begin
                        y_data_q  <= horner + off_ext;
                        y_bin_q   <= bin;
                        y_last_q  <= (bin == BIN_LAST);
                        y_valid_q <= 1'b1;
                        state     <= OUT;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                OUT: begin
                    if (bus.y_ready) begin
                        y_valid_q <= 1'b0;
                        if (y_last_q) begin
                            in_ready_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bin     <= bin + 1'b1;
                            bit_idx <= BIT_TOP;
                            state   <= RUN;
                        end
                    end
                end
                default: begin
                    in_ready_q <= 1'b1;
                    y_valid_q  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.rom_bin  = rom_bin_c;
    assign bus.rom_bits = rom_bits_c;
    assign bus.y_valid  = y_valid_q;
    assign bus.y_data   = y_data_q;
    assign bus.y_bin    = y_bin_q;
    assign bus.y_last   = y_last_q;

endmodule

// File: tb/tb_obc_dft_sequencer.sv
// Randomized bench for obc_dft_sequencer against a bin-level OBC reference model.
module tb_obc_dft_sequencer;

    localparam int DATA_W = 16;
    localparam int ROM_W  = 32;
    localparam int ACC_W  = ROM_W + 3 + DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    bit          const_mode = 1'b0;
    logic [31:0] rom_tab [16][8][4];
    logic [31:0] off_tab [16];
    logic [15:0] smp [16];
    logic [15:0] nxt [16];

    obc_dft_sequencer_if #(.DATA_W(DATA_W), .ROM_W(ROM_W)) bus ();

    obc_dft_sequencer #(
        .DATA_W (DATA_W),
        .ROM_W  (ROM_W),
        .N_BIN  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stub ROM bank: lane p is addressed by the pair (sample p+8, sample p) of the current slice.
    for (genvar p = 0; p < 8; p++) begin : g_rom
        assign bus.rom_word[p*ROM_W +: ROM_W] =
            const_mode ? 32'd1 : rom_tab[bus.rom_bin][p][{bus.rom_bits[p+8], bus.rom_bits[p]}];
    end
    assign bus.rom_off = const_mode ? 32'd0 : off_tab[bus.rom_bin];

    // Reference: y = -2^15*S15 + sum_{j<15} 2^j*S_j + off, each S_j the eight-lane sum for slice j.
    function automatic longint ref_y(input int b);
        longint y;
        longint s;
        int     code;
        y = const_mode ? 0 : longint'($signed(off_tab[b]));
        for (int j = 0; j < 16; j++) begin
            s = 0;
            for (int p = 0; p < 8; p++) begin
                code = {30'd0, smp[p+8][j], smp[p][j]};
                s += const_mode ? 1 : longint'($signed(rom_tab[b][p][code]));
            end
            if (j == 15) y -= s * (longint'(1) << j);
            else         y += s * (longint'(1) << j);
        end
        return y;
    endfunction

    function automatic logic [15:0] exp_bits(input int j);
        logic [15:0] r;
        for (int n = 0; n < 16; n++) r[n] = smp[n][j];
        return r;
    endfunction

    task automatic randomize_rom();
        for (int b = 0; b < 16; b++) begin
            off_tab[b] = $urandom;
            for (int p = 0; p < 8; p++)
                for (int c = 0; c < 4; c++) rom_tab[b][p][c] = $urandom;
        end
    endtask

    task automatic drive_samples(input bit use_next);
        for (int n = 0; n < 16; n++)
            bus.in_data[n*16 +: 16] = use_next ? nxt[n] : smp[n];
    endtask

    // Runs one frame from the current negedge; optionally stalls at stall_bin and keeps offering nxt.
    task automatic run_frame(input string tag, input int stall_bin, input bit hold_next);
        int cyc;
        logic signed [ACC_W-1:0] exp_y;
        cyc = 0;
        bus.in_valid = 1'b1;
        drive_samples(1'b0);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_ready got %0b exp 1", tag, bus.in_ready);
        end
        @(negedge clk); cyc++;
        if (hold_next) drive_samples(1'b1);
        else           bus.in_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            for (int j = 15; j >= 0; j--) begin
                checks++;
                if (bus.rom_bin !== 4'(b) || bus.rom_bits !== exp_bits(j) || bus.y_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s run_b%0d_s%0d got bin %0d bits %h yv %0b exp bin %0d bits %h yv 0",
                             tag, b, j, bus.rom_bin, bus.rom_bits, bus.y_valid, b, exp_bits(j));
                end
                @(negedge clk); cyc++;
            end
            exp_y = ACC_W'(ref_y(b));
            checks++;
            if (bus.y_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s y_valid_b%0d got %0b exp 1", tag, b, bus.y_valid);
            end
            checks++;
            if (bus.y_data !== exp_y) begin
                errors++;
                $display("FAIL %s y_data_b%0d got %0d exp %0d", tag, b, $signed(bus.y_data), exp_y);
            end
            checks++;
            if (bus.y_bin !== 4'(b)) begin
                errors++;
                $display("FAIL %s y_bin_b%0d got %0d exp %0d", tag, b, bus.y_bin, b);
            end
            checks++;
            if (bus.y_last !== (b == 15)) begin
                errors++;
                $display("FAIL %s y_last_b%0d got %0b exp %0b", tag, b, bus.y_last, b == 15);
            end
            if (b == stall_bin) begin
                bus.y_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk); cyc++;
                    checks++;
                    if (bus.y_valid !== 1'b1 || bus.y_data !== exp_y || bus.y_bin !== 4'(b) ||
                        bus.y_last !== (b == 15) || bus.rom_bits !== 16'd0 || bus.rom_bin !== 4'd0) begin
                        errors++;
                        $display("FAIL %s stall_b%0d_k%0d got yv %0b y %0d bin %0d last %0b bits %h rbin %0d exp yv 1 y %0d bin %0d bits 0",
                                 tag, b, k, bus.y_valid, $signed(bus.y_data), bus.y_bin, bus.y_last,
                                 bus.rom_bits, bus.rom_bin, exp_y, b);
                    end
                end
                bus.y_ready = 1'b1;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc !== 273 + (stall_bin >= 0 ? 10 : 0)) begin
            errors++;
            $display("FAIL %s frame_cycles got %0d exp %0d", tag, cyc, 273 + (stall_bin >= 0 ? 10 : 0));
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s end_idle got ready %0b yv %0b exp ready 1 yv 0", tag, bus.in_ready, bus.y_valid);
        end
    endtask

    task automatic new_samples();
        for (int n = 0; n < 16; n++) smp[n] = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.y_ready = 1'b1;
        bus.in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.y_valid !== 1'b0 || bus.rom_bits !== 16'd0 ||
                bus.rom_bin !== 4'd0 || bus.y_data !== '0 || bus.y_bin !== 4'd0 || bus.y_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_%0d got ready %0b yv %0b bits %h rbin %0d y %0d ybin %0d last %0b exp ready 1 rest 0",
                         k, bus.in_ready, bus.y_valid, bus.rom_bits, bus.rom_bin,
                         $signed(bus.y_data), bus.y_bin, bus.y_last);
            end
        end
    endtask

    task automatic test_const_rom();
        const_mode = 1'b1;
        for (int n = 0; n < 16; n++) smp[n] = '0;
        checks++;
        if (ref_y(0) !== -64'sd8) begin
            errors++;
            $display("FAIL const_model got %0d exp -8", ref_y(0));
        end
        run_frame("const", -1, 1'b0);
        const_mode = 1'b0;
    endtask

    task automatic test_golden();
        for (int f = 0; f < 2; f++) begin
            randomize_rom();
            new_samples();
            run_frame($sformatf("golden%0d", f), -1, 1'b0);
        end
    endtask

    task automatic test_back_pressure();
        randomize_rom();
        new_samples();
        run_frame("bp", 3, 1'b0);
    endtask

    task automatic test_busy_reject();
        randomize_rom();
        new_samples();
        for (int n = 0; n < 16; n++) nxt[n] = 16'($urandom);
        run_frame("busy1", -1, 1'b1);
        for (int n = 0; n < 16; n++) smp[n] = nxt[n];
        run_frame("busy2", -1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        randomize_rom();
        new_samples();
        bus.in_valid = 1'b1;
        drive_samples(1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // First RUN negedge is bin 0 slice 15; bin 7 slice 9 is 7*17+6 cycles later.
        repeat (7 * 17 + 6) @(negedge clk);
        checks++;
        if (bus.rom_bin !== 4'd7 || bus.rom_bits !== exp_bits(9)) begin
            errors++;
            $display("FAIL midrst_position got bin %0d bits %h exp bin 7 bits %h", bus.rom_bin, bus.rom_bits, exp_bits(9));
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.y_valid !== 1'b0 || bus.rom_bits !== 16'd0 || bus.rom_bin !== 4'd0) begin
            errors++;
            $display("FAIL midrst_abort got ready %0b yv %0b bits %h rbin %0d exp ready 1 yv 0 bits 0 rbin 0",
                     bus.in_ready, bus.y_valid, bus.rom_bits, bus.rom_bin);
        end
        rst = 1'b0;
        new_samples();
        run_frame("after_rst", -1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.y_ready  = 1'b1;
        bus.in_data  = '0;
        for (int b = 0; b < 16; b++) begin
            off_tab[b] = '0;
            for (int p = 0; p < 8; p++)
                for (int c = 0; c < 4; c++) rom_tab[b][p][c] = '0;
        end
        for (int n = 0; n < 16; n++) begin
            smp[n] = '0;
            nxt[n] = '0;
        end
        @(negedge clk);
        test_reset();
        test_const_rom();
        test_golden();
        test_back_pressure();
        test_busy_reject();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
